// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot path.
package mips_boot_pkg;

    localparam int          IMEM_WORDS_DEFAULT = 256;
    localparam logic [31:0] NOP_WORD           = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        LOAD,
        FILL,
        RUN,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four stream bytes into one little-endian word; word_valid_o pulses
// combinationally on the fourth byte so the parent can register it directly.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] buf_q, buf_d;

    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (clear_i) begin
            cnt_d = '0;
            buf_d = '0;
        end else if (byte_valid_i) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    buf_d[7:0]   = byte_i;
                2'd1:    buf_d[15:8]  = byte_i;
                2'd2:    buf_d[23:16] = byte_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    // The fourth byte bypasses the buffer and lands in the top lane.
    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, buf_q};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a counted little-endian byte stream into instruction
// memory, zero-fills the remainder and releases the core once the image is whole.
module imem_loader
    import mips_boot_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter int ADDR_W     = $clog2(IMEM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [15:0]       MAX_N    = 16'(IMEM_WORDS);
    localparam logic [ADDR_W:0]   FULL_N   = (ADDR_W + 1)'(IMEM_WORDS);
    localparam logic [ADDR_W:0]   WL_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(IMEM_WORDS - 1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        n_lo_q, n_lo_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic              fill_done_q, fill_done_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

    logic              accept;
    logic              start_ok;
    logic [15:0]       n_full;
    logic [ADDR_W:0]   wl_inc;
    logic              word_valid;
    logic [31:0]       word;

    assign accept   = in_valid && in_ready_q;
    assign start_ok = start && (state_q inside {IDLE, RUN, ERR});
    assign n_full   = {in_data, n_lo_q};
    assign wl_inc   = words_loaded_q + WL_ONE;

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (reset),
        .clear_i      (start_ok),
        .byte_valid_i (accept && (state_q == LOAD)),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        n_lo_d         = n_lo_q;
        n_d            = n_q;
        fill_done_d    = fill_done_q;
        we_d           = 1'b0;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
        err_d          = err_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_d        = HDR0;
                    err_d          = 1'b0;
                    words_loaded_d = '0;
                end
            end
            HDR0: begin
                if (accept) begin
                    n_lo_d  = in_data;
                    state_d = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    addr_d      = '0;
                    fill_done_d = 1'b0;
                    n_d         = n_full[ADDR_W:0];
                    if (n_full > MAX_N) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (n_full == 16'd0) begin
                        state_d = FILL;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_valid) begin
                    we_d           = 1'b1;
                    waddr_d        = addr_q;
                    wdata_d        = word;
                    addr_d         = addr_q + ADDR_ONE;
                    words_loaded_d = wl_inc;
                    if (wl_inc == n_q) begin
                        state_d     = FILL;
                        // A full image has nothing to fill; FILL then only closes out the last write.
                        fill_done_d = (n_q == FULL_N);
                    end
                end
            end
            FILL: begin
                if (fill_done_q) begin
                    state_d = RUN;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = NOP_WORD;
                    addr_d  = addr_q + ADDR_ONE;
                    if (addr_q == ADDR_MAX) fill_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = state_d inside {HDR0, HDR1, LOAD};
        busy_d      = state_d inside {HDR0, HDR1, LOAD, FILL};
        cpu_reset_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            n_lo_q         <= '0;
            n_q            <= '0;
            fill_done_q    <= 1'b0;
            in_ready_q     <= 1'b0;
            we_q           <= 1'b0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            cpu_reset_q    <= 1'b1;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            n_lo_q         <= n_lo_d;
            n_q            <= n_d;
            fill_done_q    <= fill_done_d;
            in_ready_q     <= in_ready_d;
            we_q           <= we_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign we           = we_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the MIPS core's instruction memory. It accepts a byte stream (16-bit little-endian word count, then program bytes), assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory. It zero-fills the unused words and holds the core in reset until the whole memory image is valid. It replaces direct bench writes of the instruction array with a real load path.

## Interface
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- ADDR_W, 8, word address width, equal to $clog2(IMEM_WORDS).

- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load. Ignored while busy.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte. A transfer occurs when in_valid && in_ready at a posedge.
- we  out  1  instruction memory write strobe, one cycle per word.
- waddr  out  ADDR_W  instruction memory word address.
- wdata  out  32  instruction word.
- cpu_reset  out  1  active-high reset to the MIPS core. High holds the core.
- busy  out  1  high in HDR0, HDR1, LOAD and FILL.
- err  out  1  sticky length error, cleared by the next start or by reset.
- words_loaded  out  ADDR_W+1  number of stream words written in the current or last load.

## Operation
- States are IDLE, HDR0, HDR1, LOAD, FILL, RUN and ERR. After reset the state is IDLE.
- **IDLE:** on start, go to HDR0 and clear err and words_loaded.
- **HDR0:** accept the count low byte, then go to HDR1.
- **HDR1:** accept the count high byte and form N.
  - N > IMEM_WORDS: go to ERR.
  - N == 0: go to FILL with waddr=0.
  - Otherwise: go to LOAD.
- **LOAD:** accept bytes b0..b3 per word and form wdata = {b3,b2,b1,b0}.
  - After the transfer of b3: we=1 for one cycle at address = word index, then increment words_loaded.
  - After word N−1 is written: if N == IMEM_WORDS go to RUN, otherwise go to FILL.
- **FILL:** write 0x00000000 (sll nop) each cycle at addresses N..IMEM_WORDS−1. After address IMEM_WORDS−1, go to RUN.
- **RUN:** cpu_reset=0 and in_ready=0.
  - start goes to HDR0, with cpu_reset rising on the same edge.
- **ERR:** cpu_reset=1, in_ready=0 and err=1. start goes to HDR0.
- start in HDR0, HDR1, LOAD or FILL has no effect.
- A byte counter (2 bits) and word address counter (ADDR_W bits) wrap naturally. No wrap occurs within a legal load because N ≤ IMEM_WORDS.
- in_valid low during LOAD stalls the load and leaves the partial word intact. There is no timeout.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, we=0, waddr=0, wdata=0, cpu_reset=1, busy=0, err=0, words_loaded=0.
- in_ready=1 exactly while in HDR0, HDR1 and LOAD, so throughput is one byte per cycle.
- Word write latency: we is high in the cycle immediately after the edge that accepted b3.
- FILL: one write per cycle with no gaps. The first FILL write is in the cycle after the last LOAD write, or in the cycle after the HDR1 transfer when N=0.
- cpu_reset falls on the edge that ends the final we cycle.
- Total load time with continuous in_valid, measured from the first header transfer edge to the cpu_reset fall: 2 + 4N + (IMEM_WORDS − N) cycles. For N == IMEM_WORDS the fill term is zero.
- If reset is asserted mid-load, all outputs immediately take their reset values and the state becomes IDLE. The memory contents are then undefined and the core stays held.

## Structure
- Shared package mips_boot_pkg:
  - state enum loader_state_t {IDLE, HDR0, HDR1, LOAD, FILL, RUN, ERR}.
  - localparam NOP_WORD = 32'h0000_0000.
  - The default IMEM_WORDS.
- Sub-module byte_packer: assembles 4 bytes into a little-endian word and emits a word_valid pulse. It is cleared on start.
- The FSM and address counters stay in imem_loader.

## Test plan
- **Basic load:** start, then stream 02 00 20 08 01 00 22 20 43 00 with in_valid held high. Required response:
  - we at waddr 0 with 0x00010820, then at waddr 1 with 0x00432022.
  - 254 zero writes at waddr 2..255.
  - cpu_reset falls 264 cycles after the first header transfer; words_loaded=2.
- **Stall:** the same stream with in_valid low for 3 cycles between b1 and b2 of word 0. Required response: identical writes, with cpu_reset falling 3 cycles later.
- **Empty load (N=0):** stream 00 00. Required response: 256 zero writes, cpu_reset falls 258 cycles after the first header transfer, words_loaded=0.
- **Length error:** stream 01 01 (N=257). Required response: state ERR, err=1, in_ready=0, cpu_reset=1, no we pulses. A following start clears err.
- **Reset mid-load:** assert reset after 5 data bytes. Required response: all outputs take reset values within the same cycle and the state is IDLE. A full reload then succeeds.
- **Reload from RUN:** start while in RUN. Required response: cpu_reset rises on the next edge and the new image overwrites memory.
